// File: rtl/sram16_ctrl_pkg.sv
// Shared types and helpers for the 32-bit to 16-bit async SRAM bridge.
package sram16_ctrl_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_DONE
    } state_t;

    // Active-low byte enables {xbheb, xbleb} for one halfword.
    // Reads always enable both bytes.
    function automatic logic [1:0] half_be_n(input logic is_wr, input logic [3:0] strb,
                                             input logic half);
        if (!is_wr) return 2'b00;
        return half ? ~strb[3:2] : ~strb[1:0];
    endfunction

    // Halfword of a 32-bit word, little-endian.
    function automatic logic [15:0] half_sel(input logic [31:0] word, input logic half);
        return half ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/sram16_ctrl_if.sv
// CPU-side memory bus between SYSTEM (master) and the SRAM bridge (slave).
interface sram16_ctrl_if #(
    parameter int ADDR_W = 19
) ();
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wr;
    logic              rd;
    logic [31:0]       rdata;
    logic              ready;
    logic              busy;

    modport master (output addr, wdata, wstrb, wr, rd,
                    input  rdata, ready, busy);

    modport slave  (input  addr, wdata, wstrb, wr, rd,
                    output rdata, ready, busy);
endinterface

// File: rtl/sram16_ctrl.sv
// Bridge from the 32-bit CPU bus to a 16-bit asynchronous SRAM.
// Each word access becomes up to two halfword cycles (SETUP/STROBE/HOLD);
// every pin output is a flop so strobes cannot glitch.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for rd/wr; latches address, data, strobes, op
// S_SETUP  | address/byte enables (and write data) set up, strobes high
// S_STROBE | xoeb or xweb low for WAIT_CYC+1 cycles
// S_HOLD   | strobes high, address and write data held
// S_DONE   | ready pulse, bus released
module sram16_ctrl
    import sram16_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 19,
    parameter int WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              resetb,
    sram16_ctrl_if.slave      bus,
    output logic [ADDR_W-2:0] xa,
    output logic [15:0]       xd_do,
    input  logic [15:0]       xd_di,
    output logic              xd_oe,
    output logic              xoeb,
    output logic              xweb,
    output logic              xbleb,
    output logic              xbheb
);

    state_t              state;
    logic                op_wr;
    logic [ADDR_W-3:0]   word_a;
    logic [31:0]         wd;
    logic [3:0]          ws;
    logic                half;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [31:0]         rdata_q;
    logic                ready_q;
    logic                busy_q;
    logic                first_half;
    logic                hi_needed;
    logic                unused_addr_lsb;

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;

    // Word accesses are aligned; the byte offset is don't-care.
    assign unused_addr_lsb = ^bus.addr[1:0];

    // A write with no low-half strobes starts directly on the high half.
    assign first_half = bus.wr && (bus.wstrb[1:0] == 2'b00);
    assign hi_needed  = !op_wr || (ws[3:2] != 2'b00);

    // Sequencer: state, wait counter, latched request and all registered pin outputs.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            word_a   <= '0;
            wd       <= '0;
            ws       <= '0;
            half     <= 1'b0;
            wait_cnt <= '0;
            rdata_q  <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            xa       <= '0;
            xd_do    <= '0;
            xd_oe    <= 1'b0;
            xoeb     <= 1'b1;
            xweb     <= 1'b1;
            xbleb    <= 1'b1;
            xbheb    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.wr || bus.rd) begin
                        op_wr  <= bus.wr;
                        word_a <= bus.addr[ADDR_W-1:2];
                        wd     <= bus.wdata;
                        ws     <= bus.wstrb;
                        busy_q <= 1'b1;
                        if (bus.wr && (bus.wstrb == 4'b0000)) begin
                            state   <= S_DONE;
                            ready_q <= 1'b1;
                        end else begin
                            state          <= S_SETUP;
                            half           <= first_half;
                            xa             <= {bus.addr[ADDR_W-1:2], first_half};
                            {xbheb, xbleb} <= half_be_n(bus.wr, bus.wstrb, first_half);
                            xd_oe          <= bus.wr;
                            if (bus.wr) xd_do <= half_sel(bus.wdata, first_half);
                        end
                    end
                end
                S_SETUP: begin
                    state    <= S_STROBE;
                    wait_cnt <= WAIT_W'(WAIT_CYC);
                    xoeb     <= op_wr;
                    xweb     <= !op_wr;
                end
                S_STROBE: begin
                    if (wait_cnt == '0) begin
                        state <= S_HOLD;
                        xoeb  <= 1'b1;
                        xweb  <= 1'b1;
                        if (!op_wr) begin
                            if (half) rdata_q[31:16] <= xd_di;
                            else      rdata_q[15:0]  <= xd_di;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!half && hi_needed) begin
                        state          <= S_SETUP;
                        half           <= 1'b1;
                        xa             <= {word_a, 1'b1};
                        {xbheb, xbleb} <= half_be_n(op_wr, ws, 1'b1);
                        if (op_wr) xd_do <= wd[31:16];
                    end else begin
                        state          <= S_DONE;
                        ready_q        <= 1'b1;
                        xd_oe          <= 1'b0;
                        {xbheb, xbleb} <= 2'b11;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram16_ctrl.sv
// Bench for sram16_ctrl: async SRAM model with access-time enforcement,
// byte-addressed reference memory, strobe and response scoreboards.
module tb_sram16_ctrl;

    localparam int AW = 19;
    localparam int WC = 2;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic [AW-2:0] xa;
    logic [15:0]   xd_do;
    logic [15:0]   xd_di = 16'h0;
    logic          xd_oe, xoeb, xweb, xbleb, xbheb;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram16_ctrl_if #(.ADDR_W(AW)) bus ();

    sram16_ctrl #(.ADDR_W(AW), .WAIT_CYC(WC)) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (bus.slave),
        .xa     (xa),
        .xd_do  (xd_do),
        .xd_di  (xd_di),
        .xd_oe  (xd_oe),
        .xoeb   (xoeb),
        .xweb   (xweb),
        .xbleb  (xbleb),
        .xbheb  (xbheb)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference memory (bytes) ----------------
    logic [7:0] ref_mem [int];

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        logic [31:0] w;
        int          k;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            k = int'({a[AW-1:2], 2'(i)});
            if (ref_mem.exists(k)) w[8*i +: 8] = ref_mem[k];
        end
        return w;
    endfunction

    // ---------------- scoreboards ----------------
    typedef struct {
        logic [AW-2:0] xa;
        logic [1:0]    be_n;
    } strb_t;

    typedef struct {
        bit          is_rd;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    strb_t exp_strb [$];
    exp_t  sb [$];

    // ---------------- async SRAM model ----------------
    logic [15:0]   sram [int];
    int            oe_cnt = 0;
    int            we_cnt = 0;
    logic [AW-2:0] pend_xa;
    logic [1:0]    pend_be;
    bit            contention = 0;

    task automatic strobe_done(input logic [AW-2:0] a, input logic [1:0] be);
        strb_t s;
        if (exp_strb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: xa %h with no access pending", a);
        end else begin
            s = exp_strb.pop_front();
            check("strobe_xa", 32'(a), 32'(s.xa));
            check("strobe_be_n", 32'(be), 32'(s.be_n));
        end
    endtask

    always @(negedge clk) begin
        logic [15:0] t;
        if (xd_oe && !xoeb) contention = 1;
        if (!xoeb) begin
            oe_cnt++;
            pend_xa = xa;
            pend_be = {xbheb, xbleb};
        end else if (oe_cnt != 0) begin
            check("oe_pulse_len", 32'(oe_cnt), 32'(WC + 1));
            strobe_done(pend_xa, pend_be);
            oe_cnt = 0;
        end
        if (!xweb) begin
            we_cnt++;
            pend_xa = xa;
            pend_be = {xbheb, xbleb};
            check("we_drive_oe", 32'(xd_oe), 32'd1);
            t = sram.exists(int'(xa)) ? sram[int'(xa)] : 16'h0;
            if (!xbleb) t[7:0]  = xd_do[7:0];
            if (!xbheb) t[15:8] = xd_do[15:8];
            sram[int'(xa)] = t;
        end else if (we_cnt != 0) begin
            check("we_pulse_len", 32'(we_cnt), 32'(WC + 1));
            strobe_done(pend_xa, pend_be);
            we_cnt = 0;
        end
        // Data only becomes valid once tAA (WC+1 cycles of xoeb low) has elapsed.
        if (!xoeb && oe_cnt >= WC + 1)
            xd_di = sram.exists(int'(xa)) ? sram[int'(xa)] : 16'h0;
        else
            xd_di = 16'h5A3C;
    end

    // ---------------- response monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (resetb && bus.ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: ready with no access pending");
            end else begin
                e = sb.pop_front();
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
                check("busy_at_ready", 32'(bus.busy), 32'd1);
                if (e.is_rd) check("rdata", bus.rdata, e.rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_access(input bit w, input bit r, input logic [AW-1:0] a,
                             input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_t  e;
        strb_t s;
        int    halves;
        int    n;
        bus.wr    = w;
        bus.rd    = r;
        bus.addr  = a;
        bus.wdata = wdata;
        bus.wstrb = wstrb;
        e.is_rd = !w;
        e.acc   = cyc + 1;
        e.rdata = '0;
        halves  = 0;
        for (int h = 0; h < 2; h++) begin
            if (!w || wstrb[2*h +: 2] != 2'b00) begin
                halves++;
                s.xa   = {a[AW-1:2], 1'(h)};
                s.be_n = w ? ~wstrb[2*h +: 2] : 2'b00;
                exp_strb.push_back(s);
            end
        end
        if (w) begin
            for (int i = 0; i < 4; i++)
                if (wstrb[i]) ref_mem[int'({a[AW-1:2], 2'(i)})] = wdata[8*i +: 8];
        end else begin
            e.rdata = ref_read(a);
        end
        e.lat = (halves == 0) ? 1 : halves * (3 + WC) + 1;
        sb.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready && n < 100);
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: no ready after %0d cycles, addr %h", n, a);
            sb.delete();
            exp_strb.delete();
        end
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        @(negedge clk);
        check("ready_pulse_width", 32'(bus.ready), 32'd0);
        check("busy_after_done", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            n;
        bus.wr = 1'b0;
        bus.rd = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        bus.wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_xa", 32'(xa), 32'd0);
        check("rst_xd", {15'd0, xd_oe, xd_do}, 32'h0);
        check("rst_strobes", {28'd0, xoeb, xweb, xbleb, xbheb}, 32'hF);
        resetb = 1'b1;
        @(negedge clk);

        // word write/read, byte strobe, zero strobe, top address, priority
        do_access(1, 0, 19'h100, 32'hDEADBEEF, 4'hF);
        do_access(0, 1, 19'h100, 32'h0, 4'h0);
        do_access(1, 0, 19'h100, 32'h11223344, 4'b0100);
        do_access(0, 1, 19'h100, 32'h0, 4'h0);
        check("byte_strobe_ref", ref_read(19'h100), 32'hDE22BEEF);
        do_access(1, 0, 19'h200, 32'hCAFEF00D, 4'b0000);
        do_access(1, 0, 19'h7FFFC, 32'h89ABCDEF, 4'hF);
        do_access(0, 1, 19'h7FFFC, 32'h0, 4'h0);
        do_access(0, 1, 19'h0, 32'h0, 4'h0);
        do_access(1, 1, 19'h40, 32'h01234567, 4'hF);
        do_access(0, 1, 19'h40, 32'h0, 4'h0);

        // reset in the middle of a write strobe
        do_access(1, 0, 19'h300, 32'h0BADF00D, 4'hF);
        bus.wr = 1'b1;
        bus.addr = 19'h300;
        bus.wdata = 32'h55AA55AA;
        bus.wstrb = 4'hF;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (xweb && n < 50);
        if (xweb) begin
            checks++;
            errors++;
            $display("FAIL reset_setup: xweb never went low");
        end
        resetb = 1'b0;
        #1;
        check("abort_xweb", 32'(xweb), 32'd1);
        check("abort_xd_oe", 32'(xd_oe), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.wr = 1'b0;
        exp_strb.delete();
        sb.delete();
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        do_access(0, 1, 19'h300, 32'h0, 4'h0);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                a = 19'h7FFFC - 19'(4 * $urandom_range(0, 3));
            else
                a = {11'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 3))
                0:       do_access(1, 1, a, $urandom, 4'($urandom));
                1:       do_access(1, 0, a, $urandom, 4'($urandom));
                default: do_access(0, 1, a, 32'h0, 4'h0);
            endcase
        end

        check("no_contention", 32'(contention), 32'd0);
        check("strobes_drained", 32'(exp_strb.size()), 32'd0);
        check("responses_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
